// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: state encoding, datapath width and
// the iteration-counter width helper used by both the divider and the multiplier.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  // One extra bit so the counter can hold WIDTH itself after the last iteration.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int MDU_CNT_W = cnt_width(MDU_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it did not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  // Extra top bit acts as the borrow flag of the WIDTH+1-bit subtract.
  assign w_diff  = {1'b0, w_shift} - {2'b00, i_divisor};
  assign o_q_bit = ~w_diff[WIDTH+1];
  // A kept difference is below the divisor, and a restored value is too, so
  // both always fit back into WIDTH bits.
  assign o_rem   = WIDTH'(o_q_bit ? w_diff : {1'b0, w_shift});

endmodule

// File: rtl/mdu_div.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle over
// magnitudes, then a single fix-up cycle that applies the latched signs.
module mdu_div
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             div_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mdu_state_e       r_state;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_q_bit;

  // Negating the most negative value wraps to itself, which is the right
  // magnitude when read as unsigned.
  assign w_dvd_abs = (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_dvs_abs = (div_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_next),
    .o_q_bit   (w_q_bit)
  );

  // NOTE: every register here is state, so only non-blocking assignments are
  // used; blocking ones would let later statements see same-edge updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (div_start) begin
            r_dvd   <= w_dvd_abs;
            r_dvs   <= w_dvs_abs;
            r_q_neg <= div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_r_neg <= div_signed & dividend[WIDTH-1];
            r_count <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Quotient bits fill the dividend register from the bottom as the
          // dividend bits leave from the top.
          r_rem   <= w_rem_next;
          r_dvd   <= {r_dvd[WIDTH-2:0], w_q_bit};
          r_count <= r_count + CNT_W'(1);
          if (r_count == LAST_ITER) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_quotient  <= r_q_neg ? -r_dvd : r_dvd;
          r_remainder <= r_r_neg ? -r_rem : r_rem;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign div_busy  = r_busy;
  assign div_done  = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule

// File: tb/tb_mdu_div.sv
// Scoreboard bench for mdu_div: directed divisions push expected results, a
// monitor pops and compares on every div_done and also tracks busy length.
module tb_mdu_div;

  localparam int W        = 32;
  localparam int BUSY_LEN = 33;

  logic         clk = 1'b0;
  logic         rst;
  logic         div_start;
  logic         div_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         div_busy;
  logic         div_done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   busy_run = 0;
  logic prev_done = 1'b0;

  mdu_div #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_start  (div_start),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares results on div_done and measures each busy interval.
  always @(negedge clk) begin
    if (rst) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_one_cycle", {63'd0, div_done}, 64'd0);
      if (div_done) begin
        check("busy_low_on_done", {63'd0, div_busy}, 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, "_q"}, {32'd0, quotient}, {32'd0, e.q});
          check({e.name, "_r"}, {32'd0, remainder}, {32'd0, e.r});
        end
      end
      if (div_busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        check("busy_len", 64'(busy_run), 64'(BUSY_LEN));
        busy_run = 0;
      end
      prev_done = div_done;
    end
  end

  // Drive a start pulse (caller is at a negedge) and queue its expected result.
  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input string name);
    exp_t e;
    check({name, "_idle_at_start"}, {63'd0, div_busy}, 64'd0);
    e.q = q; e.r = r; e.name = name;
    exp_q.push_back(e);
    div_start  = 1'b1;
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    @(negedge clk);
    div_start = 1'b0;
    check({name, "_busy_rise"}, {63'd0, div_busy}, 64'd1);
  endtask

  // Return at the negedge where div_done is high, bounded to avoid hangs.
  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (div_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic run(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] q, input logic [W-1:0] r, input string name);
    issue(sgn, a, b, q, r, name);
    wait_done(name);
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    div_start  = 1'b0;
    div_signed = 1'b0;
    dividend   = '0;
    divisor    = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, div_busy}, 64'd0);
    check("rst_done", {63'd0, div_done}, 64'd0);
    check("rst_q",    {32'd0, quotient}, 64'd0);
    check("rst_r",    {32'd0, remainder}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run(1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          "divu_100_7");
    run(1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  "div_m7_2");
    run(1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          "div_7_m2");
    run(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          "div_min_m1");
    run(1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  "divu_min_m1");
    run(1'b0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       "divu_by0");
    run(1'b1, 32'hFFFF_FFF0,  32'd0,          32'd1,          32'hFFFF_FFF0,  "div_neg_by0");

    // A second start mid-run must be ignored; outputs hold the prior result.
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "ignored_start");
    repeat (9) @(negedge clk);
    div_start  = 1'b1;
    dividend   = 32'd50;
    divisor    = 32'd5;
    @(negedge clk);
    div_start = 1'b0;
    check("hold_q_midrun", {32'd0, quotient},  64'd1);
    check("hold_r_midrun", {32'd0, remainder}, 64'h0000_0000_FFFF_FFF0);
    wait_done("ignored_start");

    // Back-to-back: start in the div_done cycle is accepted.
    issue(1'b0, 32'd20, 32'd3, 32'd6, 32'd2, "b2b_first");
    wait_done("b2b_first");
    issue(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, "b2b_second");
    wait_done("b2b_second");
    @(negedge clk);

    // Reset mid-run abandons the operation; nothing is queued for it.
    div_start  = 1'b1;
    div_signed = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    @(negedge clk);
    div_start = 1'b0;
    repeat (14) @(negedge clk);
    check("pre_rst_busy", {63'd0, div_busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", {63'd0, div_busy}, 64'd0);
    check("mid_rst_done", {63'd0, div_done}, 64'd0);
    check("mid_rst_q",    {32'd0, quotient}, 64'd0);
    check("mid_rst_r",    {32'd0, remainder}, 64'd0);
    @(negedge clk);
    run(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, "after_rst_9_3");

    repeat (40) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
